instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have the port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have the port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the port in_valid_i, input, 1 bit: a field set is present on the input.
REQ-004 SHALL have the port in_ready_o, output, 1 bit: the encoder can accept a field set.
REQ-005 SHALL have the ports in_opcode_i (7), in_func3_i (3) and in_func7_i (7), all inputs, carrying the RISC-V opcode and function fields.
REQ-006 SHALL have the ports in_rd_i, in_rs1_i and in_rs2_i, inputs, 5 bits each: the register indices.
REQ-007 SHALL have the port in_imm_i, input, 32 bits: sign-extended immediate, byte offset for branches and jumps.
REQ-008 SHALL have the port out_valid_o, output, 1 bit: an encoded word is present on the output.
REQ-009 SHALL have the port out_ready_i, input, 1 bit: the consumer accepts the output word.
REQ-010 SHALL have the port out_instr_o, output, 32 bits (INST_SIZE): the encoded instruction word.
REQ-011 SHALL have the port out_illegal_o, output, 1 bit: the field set cannot be encoded.
REQ-012 SHALL have the port count_o, output, 16 bits: count of legal words handed off at the output.

Function
REQ-013 SHALL transfer on the input when in_valid_i and in_ready_o are both 1, and on the output when out_valid_o and out_ready_i are both 1.
REQ-014 SHALL be a 2-stage pipeline:
- S1 registers the fields, the selected format and the legality check.
- S2 registers the packed word.
- An accepted field set appears on the output exactly 2 cycles later if there is no backpressure.
REQ-015 SHALL advance S1 into S2 when S1 is valid and (S2 is empty or an S2 handshake happens in the same cycle); in_ready_o = !S1 valid || S1 advancing, giving full throughput with no combinational path from in_valid_i to out_valid_o.
REQ-016 SHALL, under backpressure, hold at most 2 entries, keep out_instr_o and out_illegal_o stable while out_valid_o=1 and out_ready_i=0, and never drop, duplicate or reorder entries.
REQ-017 SHALL select the instruction format from the opcode:
- U-type: LUI, AUIPC.
- J-type: JAL.
- I-type: JALR, LOAD, ALU_I, FENCE, SYSTEM.
- S-type: STORE.
- B-type: BRANCH.
- R-type: ALU.
- Any other opcode is illegal.
REQ-018 SHALL pack the fields as follows:
- All formats: opcode at [6:0].
- Formats that have the field: rd at [11:7], func3 at [14:12], rs1 at [19:15], rs2 at [24:20].
- R-type: func7 at [31:25].
REQ-019 SHALL apply these immediate ranges and bit placements:
- I and S: -2048..2047.
- B: -4096..4094, and imm[0] must be 0.
- J: -1048576..1048574, and imm[0] must be 0.
- U: imm[11:0] must be 0; imm[31:12] is placed at [31:12].
- B and J bits are scattered per the RISC-V base format.
REQ-020 SHALL encode ALU_I shifts (func3 001 and 101) as follows:
- imm[4:0] is the shamt and must be 0..31.
- [31:25] = in_func7_i.
REQ-021 SHALL, for an illegal entry (bad opcode, imm out of range, misaligned offset, bad shamt), output out_illegal_o=1 with out_instr_o=32'h0; the entry still takes its pipeline slot and still needs an output handshake.
REQ-022 SHALL increment count_o on each output handshake with out_illegal_o=0, and saturate at 16'hFFFF.

Reset
REQ-023 SHALL, while rst_i=1 at a clock edge, clear S1 and S2 valid and drive these values: out_valid_o=0, out_illegal_o=0, out_instr_o=0, count_o=0, in_ready_o=0.
REQ-024 SHALL drive in_ready_o=1 in the first cycle after rst_i deasserts.
REQ-025 SHALL discard any entries in flight at reset, with no output for them.

Configuration
REQ-026 SHALL support the macro DECO_ENC_RV64I_EN:
- When defined: OP_ALU_I_W is accepted as I-type and OP_ALU_W as R-type.
- When defined: ALU_I shift shamt is imm[5:0], range 0..63, with [31:26] = in_func7_i[6:1].
- When defined: ALU_I_W shifts use a 5-bit shamt.
- When undefined: OP_ALU_I_W and OP_ALU_W are illegal, and shamt is 5 bits.

Verification
REQ-027 SHALL check ADDI x1,x0,5 (opcode 0010011, f3 0, rd 1, imm 5) with out_ready_i=1 -> 32'h00500093, illegal=0, out_valid_o exactly 2 cycles after accept, count_o=1.
REQ-028 SHALL check BEQ x1,x2 with imm -8 -> 32'hFE208CE3; the same with imm -7 -> illegal=1, word 0, count_o unchanged.
REQ-029 SHALL check ADDI with imm 2048 -> illegal=1; with imm -2048 -> legal, [31:20]=12'h800.
REQ-030 SHALL check that holding out_ready_i=0 while driving 4 back-to-back inputs -> exactly 2 accepted and in_ready_o=0; releasing gives words in order, with no bubble between output handshakes.
REQ-031 SHALL check SLLI x1,x1 with shamt 40 -> 32'h02809093 with DECO_ENC_RV64I_EN, illegal=1 without it.
REQ-032 SHALL check that asserting rst_i one cycle after 2 accepts -> no output appears, count_o=0, and in_ready_o=1 the cycle after release.

Source files
------------

// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: S1 decodes format and legality, S2 packs the word.
// Optional RV64I support (OP-IMM-32 / OP-32, 6-bit shamt) is enabled by defining DECO_ENC_RV64I_EN.
module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [6:0]  in_opcode_i,
  input  logic [2:0]  in_func3_i,
  input  logic [6:0]  in_func7_i,
  input  logic [4:0]  in_rd_i,
  input  logic [4:0]  in_rs1_i,
  input  logic [4:0]  in_rs2_i,
  input  logic [31:0] in_imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        out_illegal_o,
  output logic [15:0] count_o
);
  localparam int INST_SIZE = 32;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_ALU_I   = 7'b0010011;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_ALU     = 7'b0110011;
  localparam logic [6:0] OP_ALU_I_W = 7'b0011011;
  localparam logic [6:0] OP_ALU_W   = 7'b0111011;

`ifdef DECO_ENC_RV64I_EN
  localparam bit RV64 = 1'b1;
`else
  localparam bit RV64 = 1'b0;
`endif

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic        illegal;
    logic        shift;
    logic        shamt6;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } s1_t;

  s1_t                  s1_d, s1_q;
  logic                 s1_vld_q, s2_vld_q;
  logic [INST_SIZE-1:0] s2_instr_d, s2_instr_q;
  logic                 s2_ill_q;
  logic [15:0]          cnt_q;
  logic                 s1_adv, out_hs;
  logic                 fmt_ok, imm_ok, sext12;

  assign out_hs      = s2_vld_q && out_ready_i;
  assign s1_adv      = s1_vld_q && (!s2_vld_q || out_ready_i);
  assign in_ready_o  = !rst_i && (!s1_vld_q || s1_adv);
  assign out_valid_o   = s2_vld_q;
  assign out_instr_o   = s2_instr_q;
  assign out_illegal_o = s2_ill_q;
  assign count_o       = cnt_q;

  // S1 decode: format, shift detection and immediate legality
  always_comb begin
    fmt_ok = 1'b1;
    s1_d        = '0;
    s1_d.fmt    = FMT_R;
    s1_d.opcode = in_opcode_i;
    s1_d.f3     = in_func3_i;
    s1_d.f7     = in_func7_i;
    s1_d.rd     = in_rd_i;
    s1_d.rs1    = in_rs1_i;
    s1_d.rs2    = in_rs2_i;
    s1_d.imm    = in_imm_i;
    case (in_opcode_i)
      OP_LUI, OP_AUIPC:                               s1_d.fmt = FMT_U;
      OP_JAL:                                         s1_d.fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_ALU_I, OP_FENCE, OP_SYSTEM: s1_d.fmt = FMT_I;
      OP_STORE:                                       s1_d.fmt = FMT_S;
      OP_BRANCH:                                      s1_d.fmt = FMT_B;
      OP_ALU:                                         s1_d.fmt = FMT_R;
`ifdef DECO_ENC_RV64I_EN
      OP_ALU_I_W:                                     s1_d.fmt = FMT_I;
      OP_ALU_W:                                       s1_d.fmt = FMT_R;
`endif
      default:                                        fmt_ok = 1'b0;
    endcase
    // func3 001/101 are SLLI and SRLI/SRAI
    s1_d.shift  = (in_opcode_i == OP_ALU_I || (RV64 && in_opcode_i == OP_ALU_I_W))
                  && in_func3_i[1:0] == 2'b01;
    s1_d.shamt6 = RV64 && in_opcode_i == OP_ALU_I;
    sext12 = (&in_imm_i[31:11]) || !(|in_imm_i[31:11]);
    case (s1_d.fmt)
      FMT_I:   imm_ok = s1_d.shift ? (s1_d.shamt6 ? !(|in_imm_i[31:6]) : !(|in_imm_i[31:5]))
                                   : sext12;
      FMT_S:   imm_ok = sext12;
      FMT_B:   imm_ok = ((&in_imm_i[31:12]) || !(|in_imm_i[31:12])) && !in_imm_i[0];
      FMT_J:   imm_ok = ((&in_imm_i[31:20]) || !(|in_imm_i[31:20])) && !in_imm_i[0];
      FMT_U:   imm_ok = !(|in_imm_i[11:0]);
      default: imm_ok = 1'b1;
    endcase
    s1_d.illegal = !fmt_ok || !imm_ok;
  end

  always_comb begin
    s2_instr_d = '0;
    case (s1_q.fmt)
      FMT_R: s2_instr_d = {s1_q.f7, s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.opcode};
      FMT_I: begin
        if (!s1_q.shift)
          s2_instr_d = {s1_q.imm[11:0], s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.opcode};
        else if (s1_q.shamt6)
          s2_instr_d = {s1_q.f7[6:1], s1_q.imm[5:0], s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.opcode};
        else
          s2_instr_d = {s1_q.f7, s1_q.imm[4:0], s1_q.rs1, s1_q.f3, s1_q.rd, s1_q.opcode};
      end
      FMT_S: s2_instr_d = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.f3, s1_q.imm[4:0], s1_q.opcode};
      FMT_B: s2_instr_d = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.f3,
                           s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
      FMT_U: s2_instr_d = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
      FMT_J: s2_instr_d = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                           s1_q.rd, s1_q.opcode};
      default: s2_instr_d = '0;
    endcase
    if (s1_q.illegal) s2_instr_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q   <= 1'b0;
      s1_q       <= '0;
      s2_vld_q   <= 1'b0;
      s2_instr_q <= '0;
      s2_ill_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (in_ready_o) begin
        s1_vld_q <= in_valid_i;
        if (in_valid_i) s1_q <= s1_d;
      end
      if (s1_adv) begin
        s2_vld_q   <= 1'b1;
        s2_instr_q <= s2_instr_d;
        s2_ill_q   <= s1_q.illegal;
      end else if (out_hs) begin
        s2_vld_q <= 1'b0;
      end
      if (out_hs && !s2_ill_q && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed corner cases plus randomized traffic
// with random backpressure, checked against a field-rule reference model.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, out_instr;
  logic [15:0] count;

  instr_encoder dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_opcode_i(opc), .in_func3_i(f3), .in_func7_i(f7), .in_rd_i(rd),
    .in_rs1_i(rs1), .in_rs2_i(rs2), .in_imm_i(imm), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_instr_o(out_instr), .out_illegal_o(out_illegal),
    .count_o(count)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  logic [32:0] exp_q[$];
  int          cnt_exp = 0;
  bit          rand_rdy = 0;
  bit          prev_stall = 0;
  logic [32:0] prev_out;

`ifdef DECO_ENC_RV64I_EN
  localparam bit RV64 = 1'b1;
`else
  localparam bit RV64 = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: {illegal, word} from the ISA field rules
  function automatic logic [32:0] ref_enc(input logic [6:0] o, input logic [2:0] fn3,
      input logic [6:0] fn7, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [31:0] im);
    byte         fmt;
    bit          ok;
    int          s, maxsh;
    logic [31:0] w;
    s = im;
    w = 32'h0;
    case (o)
      7'h37, 7'h17:                      fmt = "U";
      7'h6F:                             fmt = "J";
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: fmt = "I";
      7'h23:                             fmt = "S";
      7'h63:                             fmt = "B";
      7'h33:                             fmt = "R";
      7'h1B:                             fmt = RV64 ? "I" : "X";
      7'h3B:                             fmt = RV64 ? "R" : "X";
      default:                           fmt = "X";
    endcase
    w[6:0] = o;
    ok = 1;
    case (fmt)
      "R": begin
        w[11:7] = d; w[14:12] = fn3; w[19:15] = s1; w[24:20] = s2; w[31:25] = fn7;
      end
      "I": begin
        w[11:7] = d; w[14:12] = fn3; w[19:15] = s1;
        if ((o == 7'h13 || o == 7'h1B) && (fn3 == 3'd1 || fn3 == 3'd5)) begin
          maxsh = (RV64 && o == 7'h13) ? 63 : 31;
          ok = s >= 0 && s <= maxsh;
          if (maxsh == 63) begin w[25:20] = im[5:0]; w[31:26] = fn7[6:1]; end
          else begin w[24:20] = im[4:0]; w[31:25] = fn7; end
        end else begin
          ok = s >= -2048 && s <= 2047;
          w[31:20] = im[11:0];
        end
      end
      "S": begin
        ok = s >= -2048 && s <= 2047;
        w[11:7] = im[4:0]; w[14:12] = fn3; w[19:15] = s1; w[24:20] = s2; w[31:25] = im[11:5];
      end
      "B": begin
        ok = s >= -4096 && s <= 4094 && (s % 2) == 0;
        w[7] = im[11]; w[11:8] = im[4:1]; w[14:12] = fn3; w[19:15] = s1; w[24:20] = s2;
        w[30:25] = im[10:5]; w[31] = im[12];
      end
      "U": begin
        ok = (s % 4096) == 0;
        w[11:7] = d; w[31:12] = im[31:12];
      end
      "J": begin
        ok = s >= -1048576 && s <= 1048574 && (s % 2) == 0;
        w[11:7] = d; w[19:12] = im[19:12]; w[20] = im[11]; w[30:21] = im[10:1]; w[31] = im[20];
      end
      default: ok = 0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h0};
  endfunction

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", {out_illegal, out_instr}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %h expected none", out_instr);
        end else begin
          e = exp_q.pop_front();
          chk("word", out_instr, e[31:0]);
          chk("illegal", out_illegal, e[32]);
          chk("count", count, cnt_exp);
          if (!e[32] && cnt_exp != 65535) cnt_exp++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_illegal, out_instr};
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom % 4) != 0;
  end

  // Called at posedge+1; returns at posedge+1 after the offered cycle
  task automatic send(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [31:0] im, output bit acc);
    opc = o; f3 = fn3; f7 = fn7; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk); #1;
    in_valid = 0;
    if (acc) exp_q.push_back(ref_enc(o, fn3, fn7, d, s1, s2, im));
  endtask

  task automatic wait_out(input string name);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = out_valid && out_ready;
    end
    chk({name, "_timeout"}, got, 1);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [6:0] ops[14] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F,
                          7'h73, 7'h23, 7'h63, 7'h33, 7'h1B, 7'h3B, 7'h7F};
  logic [31:0] edges[12] = '{32'h7FF, 32'h800, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'hFFE, 32'h1000,
                             32'hFFFF_F000, 32'h000F_FFFE, 32'h0010_0000, 32'hFFF0_0000,
                             32'd31, 32'd63};

  initial begin
    bit acc;
    int nacc, hs, guard;
    rst = 1; in_valid = 0; out_ready = 0;
    opc = 0; f3 = 0; f7 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_count", count, 0);
    rst = 0;
    #1 chk("in_ready_after_rst", in_ready, 1);
    step();

    // ADDI x1,x0,5 and its latency
    out_ready = 1;
    send(7'h13, 0, 0, 1, 0, 0, 32'd5, acc);
    chk("addi_accept", acc, 1);
    chk("addi_lat1_valid", out_valid, 0);
    step();
    chk("addi_lat2_valid", out_valid, 1);
    chk("addi_word", out_instr, 32'h0050_0093);
    chk("addi_illegal", out_illegal, 0);
    step();
    chk("addi_count", count, 1);

    send(7'h63, 0, 0, 0, 1, 2, 32'hFFFF_FFF8, acc);
    wait_out("beq8");
    chk("beq_m8_word", out_instr, 32'hFE20_8CE3);
    step();
    send(7'h63, 0, 0, 0, 1, 2, 32'hFFFF_FFF9, acc);
    wait_out("beq7");
    chk("beq_m7_illegal", out_illegal, 1);
    chk("beq_m7_word", out_instr, 0);
    step();
    chk("beq_m7_count", count, 2);

    send(7'h13, 0, 0, 1, 0, 0, 32'd2048, acc);
    wait_out("addi2048");
    chk("addi_2048_illegal", out_illegal, 1);
    step();
    send(7'h13, 0, 0, 1, 0, 0, 32'hFFFF_F800, acc);
    wait_out("addim2048");
    chk("addi_m2048_illegal", out_illegal, 0);
    chk("addi_m2048_word", out_instr, 32'h8000_0093);
    step();

    send(7'h13, 3'd1, 0, 1, 1, 0, 32'd40, acc);
    wait_out("slli40");
    chk("slli40_illegal", out_illegal, !RV64);
    chk("slli40_word", out_instr, RV64 ? 32'h0280_9093 : 32'h0);
    step(); step();

    // Backpressure: only two entries fit
    out_ready = 0;
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      send(7'h13, 0, 0, 5'(i + 3), 0, 0, 32'(i * 7), acc);
      nacc += acc;
    end
    chk("bp_accepted", nacc, 2);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1;
    hs = 0;
    for (int i = 0; i < 10 && hs == 0; i++) begin
      @(negedge clk);
      if (out_valid) hs = 1;
    end
    @(negedge clk);
    if (out_valid) hs++;
    chk("bp_no_bubble", hs, 2);
    step(); step();

    // Reset with two entries in flight
    out_ready = 0;
    send(7'h13, 0, 0, 9, 0, 0, 32'd1, acc);
    send(7'h13, 0, 0, 10, 0, 0, 32'd2, acc);
    rst = 1;
    exp_q.delete();
    cnt_exp = 0;
    step();
    rst = 0;
    #1;
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_count", count, 0);
    out_ready = 1;
    hs = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) hs++;
    end
    chk("rst2_no_output", hs, 0);
    step();

    // Random traffic with random backpressure
    rand_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ri;
      case ($urandom % 4)
        0: ri = 32'($signed($urandom_range(0, 8191)) - 4096);
        1: ri = edges[$urandom % 12];
        2: ri = $urandom & 32'hFFFF_F000;
        default: ri = $urandom;
      endcase
      if ($urandom % 5 == 0) step();
      acc = 0;
      for (int t = 0; t < 50 && !acc; t++)
        send(ops[$urandom % 14], 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), ri, acc);
      chk("rand_accept", acc, 1);
    end
    rand_rdy = 0;
    step();
    out_ready = 1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
    step();
    chk("final_count", count, cnt_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
